// File: rtl/spi_write_sequencer.sv
// Two-requester round-robin SPI write sequencer: each accepted (addr, data) request
// is sent as a 16-bit mode-0 frame {1'b1, addr[6:0], data[7:0]}, MSB first.
module spi_write_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int MAX_ADDR   = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_data,
    output logic        sclk,
    output logic        cs_n,
    output logic        copi,
    output logic        busy,
    output logic        done,
    output logic        err_addr
);

    localparam int             GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [7:0]     DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [GW-1:0]  GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [6:0]     MAX_ADDR_L = 7'(MAX_ADDR);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   frame_q, frame_d;
    logic          last_grant_q, last_grant_d;
    logic          sclk_d, cs_n_d, copi_d, done_d, err_d;
    logic [1:0]    grant;
    logic          sel;
    logic [6:0]    sel_addr;
    logic [7:0]    sel_data;

    // A requester wins outright when alone; on a tie the one not granted last time wins.
    assign grant[0] = req_valid[0] & (~req_valid[1] | last_grant_q);
    assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);

    // The error-pulse cycle blocks accepts so a rejected request costs two cycles.
    assign req_ready = (!rst && state_q == IDLE && !err_addr) ? grant : 2'b00;
    assign busy      = (state_q != IDLE);

    assign sel      = req_ready[1];
    assign sel_addr = sel ? req_addr[13:7] : req_addr[6:0];
    assign sel_data = sel ? req_data[15:8] : req_data[7:0];

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        frame_d      = frame_q;
        last_grant_d = last_grant_q;
        sclk_d       = sclk;
        cs_n_d       = cs_n;
        copi_d       = copi;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    last_grant_d = sel;
                    frame_d      = {1'b1, sel_addr, sel_data};
                    if (sel_addr > MAX_ADDR_L) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                        copi_d  = 1'b1;
                        div_d   = '0;
                        bit_d   = '0;
                    end
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = HOLD;
                        end else begin
                            // frame_q[15] is always the bit on the wire; shift the next one up.
                            bit_d   = bit_q + 4'd1;
                            frame_d = {frame_q[14:0], 1'b0};
                            copi_d  = frame_q[14];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            last_grant_q <= 1'b1;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            copi         <= 1'b0;
            done         <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            sclk         <= sclk_d;
            cs_n         <= cs_n_d;
            copi         <= copi_d;
            done         <= done_d;
            err_addr     <= err_d;
        end
    end

    // NOTE: the frame is a data register reloaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Directed bench for spi_write_sequencer: default instance plus a CLK_DIV=1, GAP_CYCLES=1 instance.
module tb_spi_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [13:0] req_addr;
    logic [15:0] req_data;
    logic        sclk, cs_n, copi, busy, done, err_addr;

    logic [1:0]  f_valid;
    logic [1:0]  f_ready;
    logic [13:0] f_addr;
    logic [15:0] f_data;
    logic        f_sclk, f_cs_n, f_copi, f_busy, f_done, f_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_write_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .sclk(sclk), .cs_n(cs_n), .copi(copi),
        .busy(busy), .done(done), .err_addr(err_addr)
    );

    spi_write_sequencer #(.CLK_DIV(1), .MAX_ADDR(4), .GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst(rst),
        .req_valid(f_valid), .req_ready(f_ready),
        .req_addr(f_addr), .req_data(f_data),
        .sclk(f_sclk), .cs_n(f_cs_n), .copi(f_copi),
        .busy(f_busy), .done(f_done), .err_addr(f_err)
    );

    // Checks the current negedge sample first, then advances one negedge at a time.
    task automatic wait_ready(input bit fast, input int which, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 400; i++) begin
            if (( fast && f_ready[which]) || (!fast && req_ready[which])) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_any(output int idx, output int t, output bit ok);
        ok  = 1'b0;
        idx = -1;
        t   = 0;
        for (int i = 0; i < 400; i++) begin
            if (req_ready != 2'b00) begin
                ok  = 1'b1;
                idx = req_ready[1] ? 1 : 0;
                t   = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Samples a frame from the cycle after accept until busy drops.
    task automatic capture(input bit fast, output logic [15:0] bits, output int cs_low,
                           output int rises, output int toggles, output int dones,
                           output int end_cyc, output bit ok);
        logic s, c, d, b, dn, prev_s;
        bits = '0; cs_low = 0; rises = 0; toggles = 0; dones = 0; end_cyc = 0; ok = 1'b0;
        prev_s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            s  = fast ? f_sclk : sclk;
            c  = fast ? f_cs_n : cs_n;
            d  = fast ? f_copi : copi;
            b  = fast ? f_busy : busy;
            dn = fast ? f_done : done;
            if (!c) cs_low++;
            if (!c && s != prev_s) toggles++;
            if (s && !prev_s) begin
                rises++;
                bits = {bits[14:0], d};
            end
            if (dn) dones++;
            prev_s = s;
            if (!b) begin
                end_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b00; req_addr = '0; req_data = '0;
        f_valid = 2'b00; f_addr = '0; f_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk, cs_n, copi, busy, done, err_addr} !== 6'b010000) begin
            errors++;
            $display("FAIL reset_outputs: got sclk,cs_n,copi,busy,done,err=%b want 010000",
                     {sclk, cs_n, copi, busy, done, err_addr});
        end
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        req_valid = 2'b00;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        int t, e, csl, r, tg, dn; logic [15:0] bits; bit ok;
        @(posedge clk); #1;
        req_valid = 2'b01; req_addr = {7'd0, 7'h02}; req_data = {8'h00, 8'hA5};
        @(negedge clk);
        wait_ready(0, 0, t, ok);
        checks++;
        if (!ok || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got ok=%0b ready=%b want 1 01", ok, req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        capture(0, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h82A5) begin
            errors++; $display("FAIL single_frame: got %h want 82a5", bits);
        end
        checks++;
        if (csl != 132 || r != 16) begin
            errors++; $display("FAIL single_timing: got cs_low=%0d rises=%0d want 132 16", csl, r);
        end
        checks++;
        if (dn != 1) begin
            errors++; $display("FAIL single_done: got %0d pulses want 1", dn);
        end
        checks++;
        if (!ok || e - t != 141) begin
            errors++; $display("FAIL single_busy: got %0d cycles want 141", e - t);
        end
    endtask

    task automatic test_both_from_reset;
        int t0, t1, e, csl, r, tg, dn; logic [15:0] bits; bit ok;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b11; req_addr = {7'h04, 7'h00}; req_data = {8'h22, 8'h11};
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        wait_ready(0, 0, t0, ok);
        checks++;
        if (!ok || req_ready !== 2'b01) begin
            errors++; $display("FAIL tie_first: got ok=%0b ready=%b want 1 01", ok, req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b10;
        capture(0, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h8011) begin
            errors++; $display("FAIL tie_frame0: got %h want 8011", bits);
        end
        wait_ready(0, 1, t1, ok);
        checks++;
        if (!ok || t1 - t0 != 141) begin
            errors++; $display("FAIL tie_spacing: got %0d want 141", t1 - t0);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        capture(0, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h8422) begin
            errors++; $display("FAIL tie_frame1: got %h want 8422", bits);
        end
    endtask

    task automatic test_round_robin;
        int idx, t, tprev, e, csl, r, tg, dn; logic [15:0] bits; bit ok;
        tprev = 0;
        @(posedge clk); #1;
        req_valid = 2'b11; req_addr = {7'h01, 7'h00}; req_data = {8'h02, 8'h01};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wait_any(idx, t, ok);
            checks++;
            if (!ok || idx != (i % 2)) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, idx, i % 2);
            end
            if (i > 0) begin
                checks++;
                if (t - tprev != 141) begin
                    errors++; $display("FAIL rr_spacing[%0d]: got %0d want 141", i, t - tprev);
                end
            end
            tprev = t;
            @(posedge clk); #1;
            if (idx == 1) req_data[15:8] = req_data[15:8] + 8'h10;
            else          req_data[7:0]  = req_data[7:0] + 8'h10;
            if (i == 3) req_valid = 2'b00;
            @(negedge clk);
        end
        capture(0, bits, csl, r, tg, dn, e, ok);
    endtask

    task automatic test_bad_addr;
        int t, e, csl, r, tg, dn; logic [15:0] bits; bit ok;
        @(posedge clk); #1;
        req_valid = 2'b10; req_addr = {7'h05, 7'h00}; req_data = {8'hFF, 8'h00};
        @(negedge clk);
        wait_ready(0, 1, t, ok);
        checks++;
        if (!ok || req_ready !== 2'b10) begin
            errors++; $display("FAIL bad_ready: got ok=%0b ready=%b want 1 10", ok, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b01; req_addr = {7'h00, 7'h01}; req_data = {8'h00, 8'h5A};
        @(negedge clk);
        checks++;
        if ({err_addr, cs_n, busy, done, req_ready} !== 6'b110000) begin
            errors++;
            $display("FAIL bad_err_cycle: got err,cs_n,busy,done,ready=%b want 110000",
                     {err_addr, cs_n, busy, done, req_ready});
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || err_addr !== 1'b0) begin
            errors++;
            $display("FAIL bad_next_accept: got ready=%b err=%b want 01 0", req_ready, err_addr);
        end
        @(posedge clk); #1 req_valid = 2'b00;
        capture(0, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h815A || dn != 1) begin
            errors++; $display("FAIL bad_follow_frame: got %h done=%0d want 815a 1", bits, dn);
        end
    endtask

    task automatic test_reset_mid_frame;
        int t, e, csl, r, tg, dn, lows; logic [15:0] bits; bit ok;
        @(posedge clk); #1;
        req_valid = 2'b01; req_addr = {7'h00, 7'h03}; req_data = {8'h00, 8'hC3};
        @(negedge clk);
        wait_ready(0, 0, t, ok);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (60) @(negedge clk);
        checks++;
        if (!ok || copi !== 1'b1 || sclk !== 1'b0 || cs_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit7: got copi=%b sclk=%b cs_n=%b want 1 0 0", copi, sclk, cs_n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({sclk, cs_n, copi, busy, done, err_addr} !== 6'b010000) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b want 010000",
                     {sclk, cs_n, copi, busy, done, err_addr});
        end
        @(posedge clk); #1 rst = 1'b0;
        dn = 0; lows = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (!cs_n) lows++;
        end
        checks++;
        if (dn != 0 || lows != 0) begin
            errors++; $display("FAIL mid_abandon: got done=%0d cs_low=%0d want 0 0", dn, lows);
        end
        @(posedge clk); #1;
        req_valid = 2'b10; req_addr = {7'h04, 7'h00}; req_data = {8'h3C, 8'h00};
        @(negedge clk);
        wait_ready(0, 1, t, ok);
        @(posedge clk); #1 req_valid = 2'b00;
        capture(0, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h843C || csl != 132 || dn != 1) begin
            errors++;
            $display("FAIL mid_fresh_frame: got %h cs_low=%0d done=%0d want 843c 132 1", bits, csl, dn);
        end
    endtask

    task automatic test_fast;
        int t0, t1, e, csl, r, tg, dn; logic [15:0] bits; bit ok;
        @(posedge clk); #1;
        f_valid = 2'b01; f_addr = {7'h00, 7'h03}; f_data = 16'h0000;
        @(negedge clk);
        wait_ready(1, 0, t0, ok);
        capture(1, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h8300) begin
            errors++; $display("FAIL fast_frame: got %h want 8300", bits);
        end
        checks++;
        if (csl != 33 || r != 16 || tg != 32 || dn != 1) begin
            errors++;
            $display("FAIL fast_timing: got cs_low=%0d rises=%0d toggles=%0d done=%0d want 33 16 32 1",
                     csl, r, tg, dn);
        end
        wait_ready(1, 0, t1, ok);
        checks++;
        if (!ok || t1 - t0 != 35) begin
            errors++; $display("FAIL fast_spacing: got %0d want 35", t1 - t0);
        end
        @(posedge clk); #1 f_valid = 2'b00;
        capture(1, bits, csl, r, tg, dn, e, ok);
        checks++;
        if (bits !== 16'h8300) begin
            errors++; $display("FAIL fast_frame2: got %h want 8300", bits);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_both_from_reset();
        test_round_robin();
        test_bad_addr();
        test_reset_mid_frame();
        test_fast();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
